video_timing_gen: RTL and testbench

- Transmit-side raster timing source for the SLI HDMI output path.
- Generates hsync, vsync, blank and pixel coordinates from programmable horizontal and vertical timing parameters.
- Feeds the pattern generator and the per-bit sync delay stages downstream.
- All outputs are registered in the pixel clock domain.

---
 rtl/video_timing_gen.sv | 118 +++++++++++
 tb/tb_video_timing_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing source for the HDMI transmit path.
// A free-running (h, v) position counter is decoded each enabled cycle into
// registered sync, blank, coordinate and start-of-line/frame outputs, so every
// output describes the pixel the counter held on the previous edge.
module video_timing_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CW       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Boundaries cast to the counter width so every compare is width-matched.
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

    logic [CW-1:0] h_cnt_reg;
    logic [CW-1:0] v_cnt_reg;
    logic [CW-1:0] h_cnt_next;
    logic [CW-1:0] v_cnt_next;

    logic          active_next;
    logic          hsync_next;
    logic          vsync_next;
    logic [CW-1:0] x_next;
    logic [CW-1:0] y_next;
    logic          line_start_next;
    logic          frame_start_next;

    // Position advance: h wraps at end of line, v steps only on that wrap.
    always_comb begin
        h_cnt_next = h_cnt_reg + 1'b1;
        v_cnt_next = v_cnt_reg;
        if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            if (v_cnt_reg == V_LAST) begin
                v_cnt_next = '0;
            end else begin
                v_cnt_next = v_cnt_reg + 1'b1;
            end
        end
    end

    // Decode of the current position into the values the outputs will load.
    // vsync depends on v only, so it naturally changes on h=0 pixels.
    always_comb begin
        active_next      = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
        hsync_next       = ((h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END))
                           ? HS_POL : ~HS_POL;
        vsync_next       = ((v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END))
                           ? VS_POL : ~VS_POL;
        x_next           = active_next ? h_cnt_reg : '0;
        y_next           = active_next ? v_cnt_reg : '0;
        line_start_next  = (h_cnt_reg == '0);
        frame_start_next = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    end

    // Counters and registered outputs; reset wins over en, and a stalled
    // cycle holds levels while killing the pulses so each is one cycle wide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_reg   <= '0;
            v_cnt_reg   <= '0;
            frame_cnt   <= '0;
            blank       <= 1'b1;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            h_cnt_reg   <= h_cnt_next;
            v_cnt_reg   <= v_cnt_next;
            blank       <= ~active_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            x           <= x_next;
            y           <= y_next;
            line_start  <= line_start_next;
            frame_start <= frame_start_next;
            if (frame_start_next) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small 14x7 raster.
// A frame-position model (single pixel index 0..97) predicts every output and
// is compared each cycle; directed literal checks pin the model and boundaries.
module tb_video_timing_gen;

    localparam int CW       = 12;
    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 1;
    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = HT * VT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          hsync;
    logic          vsync;
    logic          blank;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic [7:0]    frame_cnt;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- model: position is a single pixel index in the frame
    function automatic int m_h(input int p); return p % HT; endfunction
    function automatic int m_v(input int p); return p / HT; endfunction
    function automatic logic m_active(input int p);
        return (m_h(p) < H_ACTIVE) && (m_v(p) < V_ACTIVE);
    endfunction
    function automatic logic m_hs(input int p);
        return (m_h(p) >= H_ACTIVE + H_FP) && (m_h(p) < H_ACTIVE + H_FP + H_SYNC);
    endfunction
    function automatic logic m_vs(input int p);
        return (m_v(p) >= V_ACTIVE + V_FP) && (m_v(p) < V_ACTIVE + V_FP + V_SYNC);
    endfunction

    int            m_pos = 0;
    logic [7:0]    m_fc  = 8'd0;
    logic          chk_on = 1'b0;
    logic          e_hs, e_vs, e_bl, e_ls, e_fs;
    logic [CW-1:0] e_x, e_y;

    always @(posedge clk) begin
        if (rst_n === 1'b0) begin
            chk_on <= 1'b1;
            m_pos  <= 0;
            m_fc   <= 8'd0;
            e_hs   <= 1'b0;
            e_vs   <= 1'b0;
            e_bl   <= 1'b1;
            e_ls   <= 1'b0;
            e_fs   <= 1'b0;
            e_x    <= '0;
            e_y    <= '0;
        end else if (en === 1'b1) begin
            e_hs  <= m_hs(m_pos);
            e_vs  <= m_vs(m_pos);
            e_bl  <= ~m_active(m_pos);
            e_ls  <= (m_h(m_pos) == 0);
            e_fs  <= (m_pos == 0);
            e_x   <= m_active(m_pos) ? CW'(m_h(m_pos)) : '0;
            e_y   <= m_active(m_pos) ? CW'(m_v(m_pos)) : '0;
            if (m_pos == 0) m_fc <= m_fc + 8'd1;
            m_pos <= (m_pos + 1) % FRAME;
        end else begin
            e_ls <= 1'b0;
            e_fs <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("m_hsync", 32'(hsync), 32'(e_hs));
            check("m_vsync", 32'(vsync), 32'(e_vs));
            check("m_blank", 32'(blank), 32'(e_bl));
            check("m_x", 32'(x), 32'(e_x));
            check("m_y", 32'(y), 32'(e_y));
            check("m_line_start", 32'(line_start), 32'(e_ls));
            check("m_frame_start", 32'(frame_start), 32'(e_fs));
            check("m_frame_cnt", 32'(frame_cnt), 32'(m_fc));
        end
    end

    // ---------------- directed stimulus with literal expectations
    int ls_n, vs_n, fs_n, blank_late, first_vs;

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;   // reset must override en
        repeat (3) @(negedge clk);
        check("rst_blank", 32'(blank), 1);
        check("rst_hsync", 32'(hsync), 0);
        check("rst_vsync", 32'(vsync), 0);
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_ls", 32'(line_start), 0);
        check("rst_fs", 32'(frame_start), 0);
        check("rst_fc", 32'(frame_cnt), 0);
        $display("txn reset: blank=%0b x=%0d fc=%0d", blank, x, frame_cnt);

        rst_n = 1'b1;
        ls_n = 0; vs_n = 0; fs_n = 0; blank_late = 0; first_vs = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("e1_x", 32'(x), 0);
                check("e1_y", 32'(y), 0);
                check("e1_blank", 32'(blank), 0);
                check("e1_fs", 32'(frame_start), 1);
                check("e1_ls", 32'(line_start), 1);
                check("e1_fc", 32'(frame_cnt), 1);
            end
            if (k >= 2 && k <= 8) check("x_ramp", 32'(x), 32'(k - 1));
            if (k == 9) begin
                check("e9_blank", 32'(blank), 1);
                check("e9_x", 32'(x), 0);
            end
            if (k == 11 || k == 12) check("hs_on", 32'(hsync), 1);
            if (k == 10 || k == 13) check("hs_off", 32'(hsync), 0);
            if (k == 15) begin
                check("e15_ls", 32'(line_start), 1);
                check("e15_y", 32'(y), 1);
            end
            ls_n += int'(line_start);
            vs_n += int'(vsync);
            fs_n += int'(frame_start);
            if (vsync && first_vs == 0) first_vs = k;
            if (k > 4 * HT) blank_late += int'(blank);
        end
        check("ls_per_frame", 32'(ls_n), 7);
        check("vs_len", 32'(vs_n), 14);
        check("vs_first_edge", 32'(first_vs), 71);
        check("fs_per_frame", 32'(fs_n), 1);
        check("blank_lines4_6", 32'(blank_late), 42);
        $display("txn frame1: ls=%0d vs=%0d first_vs=%0d fs=%0d", ls_n, vs_n, first_vs, fs_n);

        @(negedge clk);
        check("f2_fs", 32'(frame_start), 1);
        check("f2_fc", 32'(frame_cnt), 2);

        // Stall mid-line at x=3.
        repeat (3) @(negedge clk);
        check("pre_stall_x", 32'(x), 3);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_x", 32'(x), 3);
            check("stall_ls", 32'(line_start), 0);
            check("stall_blank", 32'(blank), 0);
        end
        en = 1'b1;
        @(negedge clk);
        check("resume_x", 32'(x), 4);
        $display("txn stall: resumed at x=%0d", x);

        // Stall exactly where frame_start would fire.
        repeat (93) @(negedge clk);
        check("last_px_blank", 32'(blank), 1);
        check("last_px_hs", 32'(hsync), 0);
        check("last_px_fc", 32'(frame_cnt), 2);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fs_stall", 32'(frame_start), 0);
            check("fc_stall", 32'(frame_cnt), 2);
        end
        en = 1'b1;
        @(negedge clk);
        check("fs_resume", 32'(frame_start), 1);
        check("fc_resume", 32'(frame_cnt), 3);
        @(negedge clk);
        check("fs_once", 32'(frame_start), 0);
        check("fc_once", 32'(frame_cnt), 3);
        $display("txn fs_stall: fc=%0d", frame_cnt);

        // Reset mid-frame at line 2, x=5.
        repeat (32) @(negedge clk);
        check("mid_x", 32'(x), 5);
        check("mid_y", 32'(y), 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_blank", 32'(blank), 1);
        check("mrst_x", 32'(x), 0);
        check("mrst_y", 32'(y), 0);
        check("mrst_fc", 32'(frame_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_x", 32'(x), 0);
        check("post_rst_blank", 32'(blank), 0);
        check("post_rst_fs", 32'(frame_start), 1);
        check("post_rst_fc", 32'(frame_cnt), 1);
        $display("txn mid_reset: fc=%0d fs=%0b", frame_cnt, frame_start);

        // frame_cnt wrap 255 -> 0.
        repeat (255 * FRAME - 1) @(negedge clk);
        check("fc_255", 32'(frame_cnt), 255);
        @(negedge clk);
        check("fc_wrap", 32'(frame_cnt), 0);
        check("fc_wrap_fs", 32'(frame_start), 1);
        $display("txn wrap: fc=%0d", frame_cnt);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
